// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the shared-adder arbiter slice.
package adder_share_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int CW_DEF   = 16;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/adder_share_arb_rr_arbiter.sv
// Combinational round-robin picker: searches from last+1 upward (mod N).
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int  N  = NREQ_DEF,
  localparam int LW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [LW-1:0] gnt_idx
);

  logic [LW-1:0] cand_s;
  logic [LW-1:0] idx_s;
  logic          hit_s;

  // First requester at or after last+1, wrapping.
  always_comb begin
    cand_s = '0;
    idx_s  = '0;
    hit_s  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand_s = LW'((int'(last) + k) % N);
      if (!hit_s && req[cand_s]) begin
        hit_s = 1'b1;
        idx_s = cand_s;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign gnt_idx = idx_s;

  // One-hot grant, only while the datapath can take a request.
  always_comb begin
    gnt = '0;
    if (en && hit_s) begin
      gnt[idx_s] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// One DW-bit adder shared by NREQ requesters under round-robin arbitration,
// with a registered valid/ready result channel and a completed-op counter.
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_a,
  input  logic [NREQ*DW-1:0]       req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DW-1:0]            rsp_sum,
  output logic                     rsp_carry,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     busy,
  output logic [CW-1:0]            op_count
);

  localparam int IW = idx_w(NREQ);

  state_e        state_r;
  state_e        state_nxt_s;
  logic [IW-1:0] last_grant_r;
  logic [NREQ-1:0] gnt_s;
  logic [IW-1:0] gnt_idx_s;
  logic          can_accept_s;
  logic          accept_s;
  logic          rsp_hs_s;
  logic [DW-1:0] a_sel_s;
  logic [DW-1:0] b_sel_s;
  logic [DW:0]   sum_s;

  logic          rsp_valid_r;
  logic [DW-1:0] rsp_sum_r;
  logic          rsp_carry_r;
  logic [IW-1:0] rsp_id_r;
  logic [CW-1:0] op_count_r;

  // rsp_ready feeds req_ready directly so a drained result can be replaced
  // in the same cycle; nothing is granted while reset is asserted.
  assign can_accept_s = rstn && ((state_r == IDLE) || ((state_r == HOLD) && rsp_ready));
  assign rsp_hs_s     = rsp_valid_r && rsp_ready;
  assign accept_s     = |gnt_s;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .req     (req_valid),
    .last    (last_grant_r),
    .en      (can_accept_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign a_sel_s = req_a[int'(gnt_idx_s)*DW +: DW];
  assign b_sel_s = req_b[int'(gnt_idx_s)*DW +: DW];
  assign sum_s   = {1'b0, a_sel_s} + {1'b0, b_sel_s};

  // Next-state: a new accept always lands in HOLD, otherwise drain on handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (accept_s) begin
          state_nxt_s = HOLD;
        end else if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, result registers, arbitration pointer and op counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= IDLE;
      rsp_valid_r  <= 1'b0;
      rsp_sum_r    <= '0;
      rsp_carry_r  <= 1'b0;
      rsp_id_r     <= '0;
      last_grant_r <= IW'(NREQ - 1);
      op_count_r   <= '0;
    end else begin
      state_r     <= state_nxt_s;
      rsp_valid_r <= (state_nxt_s == HOLD);
      if (accept_s) begin
        rsp_carry_r  <= sum_s[DW];
        rsp_sum_r    <= sum_s[DW-1:0];
        rsp_id_r     <= gnt_idx_s;
        last_grant_r <= gnt_idx_s;
      end
      if (rsp_hs_s) begin
        op_count_r <= op_count_r + CW'(1);
      end
    end
  end

  assign req_ready = gnt_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = rsp_sum_r;
  assign rsp_carry = rsp_carry_r;
  assign rsp_id    = rsp_id_r;
  assign busy      = (state_r == HOLD);
  assign op_count  = op_count_r;

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboarded bench for adder_share_arb: a negedge reference model predicts
// grants and results; scenario tasks add targeted inline checks.
module tb_adder_share_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int CW   = 16;

  logic             clk;
  logic             rstn;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]  req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_sum;
  logic             rsp_carry;
  logic [1:0]       rsp_id;
  logic             busy;
  logic [CW-1:0]    op_count;

  int n_vec;
  int n_err;

  typedef struct packed {
    logic [1:0] id;
    logic       carry;
    logic [7:0] sum;
  } exp_t;

  exp_t        sb_q[$];
  logic        m_hold;
  logic [1:0]  m_last;
  logic [15:0] m_cnt;
  logic        mon_en;

  adder_share_arb #(
    .NREQ (NREQ),
    .DW   (DW),
    .CW   (CW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] model_gnt(input logic [3:0] v, input logic [1:0] last);
    logic [3:0] g;
    logic [1:0] c;
    g = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      c = last + 2'(k);
      if (g == 4'b0000 && v[c]) g[c] = 1'b1;
    end
    return g;
  endfunction

  // Reference model: checks outputs of the current cycle, then predicts the next edge.
  always @(negedge clk) begin
    logic [3:0] eg;
    int gi;
    exp_t e;
    logic [8:0] s;
    if (mon_en) begin
      eg = (rstn && (!m_hold || rsp_ready)) ? model_gnt(req_valid, m_last) : 4'b0000;
      n_vec++; if (req_ready !== eg) begin n_err++; $display("FAIL mon_req_ready got %b exp %b", req_ready, eg); end
      n_vec++; if (rsp_valid !== m_hold) begin n_err++; $display("FAIL mon_rsp_valid got %b exp %b", rsp_valid, m_hold); end
      n_vec++; if (busy !== m_hold) begin n_err++; $display("FAIL mon_busy got %b exp %b", busy, m_hold); end
      n_vec++; if (op_count !== m_cnt) begin n_err++; $display("FAIL mon_op_count got %0d exp %0d", op_count, m_cnt); end
      if (!rstn) begin
        sb_q.delete();
        m_hold = 1'b0;
        m_last = 2'd3;
        m_cnt  = 16'd0;
      end else begin
        if (m_hold && rsp_ready) begin
          n_vec++;
          if (sb_q.size() == 0) begin
            n_err++; $display("FAIL sb_underflow got handshake exp none");
          end else begin
            e = sb_q.pop_front();
            if ({rsp_id, rsp_carry, rsp_sum} !== e) begin
              n_err++;
              $display("FAIL sb_result got id=%0d c=%b s=%h exp id=%0d c=%b s=%h",
                       rsp_id, rsp_carry, rsp_sum, e.id, e.carry, e.sum);
            end
          end
          m_cnt = m_cnt + 16'd1;
        end
        if (eg != 4'b0000) begin
          gi = 0;
          for (int i = 0; i < 4; i++) if (eg[i]) gi = i;
          s = {1'b0, req_a[gi*8 +: 8]} + {1'b0, req_b[gi*8 +: 8]};
          e.id = 2'(gi); e.carry = s[8]; e.sum = s[7:0];
          sb_q.push_back(e);
          m_last = 2'(gi);
        end
        m_hold = (eg != 4'b0000) || (m_hold && !rsp_ready);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
    req_a = '0; req_b = '0;
    tick();
    mon_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
      n_vec++; if ({rsp_id, rsp_carry, rsp_sum} !== 11'd0) begin n_err++; $display("FAIL rst_rsp_fields got %h exp 0", {rsp_id, rsp_carry, rsp_sum}); end
      n_vec++; if (op_count !== 16'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_cnt_busy got %0d/%b exp 0/0", op_count, busy); end
      tick();
    end
    rstn = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL first_grant got %b exp 0001", req_ready); end
    drain();
  endtask

  task automatic test_single_carry();
    logic [15:0] base;
    tick();
    req_valid = 4'b0100; req_a[16 +: 8] = 8'hF0; req_b[16 +: 8] = 8'h20; rsp_ready = 1'b1;
    base = m_cnt;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 8'h10 || rsp_carry !== 1'b1 || rsp_id !== 2'd2) begin
      n_err++; $display("FAIL single_result got v=%b s=%h c=%b id=%0d exp v=1 s=10 c=1 id=2", rsp_valid, rsp_sum, rsp_carry, rsp_id);
    end
    tick();
    @(negedge clk);
    n_vec++; if (op_count !== base + 16'd1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_count got %0d/%b exp %0d/0", op_count, rsp_valid, base + 16'd1); end
    drain();
  endtask

  task automatic test_round_robin();
    tick(); rstn = 1'b0; req_valid = 4'b0000;
    tick(); rstn = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_a[(k % 4)*8 +: 8] = 8'(k * 16 + 3);
      req_b[(k % 4)*8 +: 8] = 8'(k + 200);
      @(negedge clk);
      n_vec++; if (req_ready !== (4'b0001 << (k % 4))) begin n_err++; $display("FAIL rr_grant k=%0d got %b exp %b", k, req_ready, 4'b0001 << (k % 4)); end
      if (k > 0) begin
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4)) begin n_err++; $display("FAIL rr_id k=%0d got %b/%0d exp 1/%0d", k, rsp_valid, rsp_id, (k - 1) % 4); end
      end
      tick();
    end
    req_valid = 4'b0000;
    @(negedge clk);
    n_vec++; if (rsp_id !== 2'd3 || op_count !== 16'd7) begin n_err++; $display("FAIL rr_tail got id=%0d cnt=%0d exp id=3 cnt=7", rsp_id, op_count); end
    tick();
    @(negedge clk);
    n_vec++; if (op_count !== 16'd8) begin n_err++; $display("FAIL rr_count got %0d exp 8", op_count); end
    drain();
  endtask

  task automatic test_backpressure();
    tick();
    req_valid = 4'b0001; req_a[0 +: 8] = 8'h55; req_b[0 +: 8] = 8'h66; rsp_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_first got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0010; req_a[0 +: 8] = 8'hAA; req_a[8 +: 8] = 8'h01; req_b[8 +: 8] = 8'h02;
    repeat (5) begin
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 8'hBB || rsp_carry !== 1'b0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
        n_err++; $display("FAIL bp_hold got v=%b s=%h c=%b id=%0d rdy=%b exp v=1 s=bb c=0 id=0 rdy=0000", rsp_valid, rsp_sum, rsp_carry, rsp_id, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'h03) begin n_err++; $display("FAIL bp_nobubble got v=%b id=%0d s=%h exp v=1 id=1 s=03", rsp_valid, rsp_id, rsp_sum); end
    drain();
  endtask

  task automatic test_boundary();
    logic [7:0] ta [3];
    logic [7:0] tb_v [3];
    logic [7:0] es [3];
    logic       ec [3];
    ta = '{8'hFF, 8'h00, 8'h7F};
    tb_v = '{8'h01, 8'h00, 8'h80};
    es = '{8'h00, 8'h00, 8'hFF};
    ec = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) begin
        req_valid = 4'b1000; req_a[24 +: 8] = ta[k]; req_b[24 +: 8] = tb_v[k];
      end else begin
        req_valid = 4'b0000;
      end
      @(negedge clk);
      if (k > 0) begin
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_sum !== es[k-1] || rsp_carry !== ec[k-1]) begin
          n_err++; $display("FAIL boundary_%0d got v=%b s=%h c=%b exp v=1 s=%h c=%b", k - 1, rsp_valid, rsp_sum, rsp_carry, es[k-1], ec[k-1]);
        end
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_hold();
    tick();
    req_valid = 4'b0001; req_a[0 +: 8] = 8'h12; req_b[0 +: 8] = 8'h34; rsp_ready = 1'b0;
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL midhold_pre got %b exp 1", rsp_valid); end
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0 || op_count !== 16'd0 || busy !== 1'b0) begin n_err++; $display("FAIL midhold_rst got v=%b cnt=%0d busy=%b exp 0/0/0", rsp_valid, op_count, busy); end
    drain();
  endtask

  task automatic test_counter_wrap();
    tick(); rstn = 1'b0; req_valid = 4'b0000;
    tick(); rstn = 1'b1; req_valid = 4'b0001; rsp_ready = 1'b1;
    req_a[0 +: 8] = 8'h01; req_b[0 +: 8] = 8'h01;
    repeat (65536) tick();
    req_valid = 4'b0000;
    @(negedge clk);
    n_vec++; if (op_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_max got %h exp ffff", op_count); end
    tick();
    @(negedge clk);
    n_vec++; if (op_count !== 16'h0000 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL wrap_zero got %h/%b exp 0000/0", op_count, rsp_valid); end
    drain();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    mon_en = 1'b0; m_hold = 1'b0; m_last = 2'd3; m_cnt = 16'd0;
    rstn = 1'b0; req_valid = 4'b0000; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    test_reset();
    test_single_carry();
    test_round_robin();
    test_backpressure();
    test_boundary();
    test_reset_mid_hold();
    test_counter_wrap();
    n_vec++; if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d exp 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one 8-bit add datapath among NREQ independent requesters.
- Round-robin arbitration of valid/ready requests; one add per accepted request.
- Registered result (sum, carry, requester id) on a single valid/ready response channel with backpressure.
- Sits between client blocks and the add resource; also keeps a wrapping completed-operation counter.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, operand and sum width
- CW, 16, width of completed-operation counter

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*DW  operand A, requester i at bits [i*DW +: DW]
- req_b  in  NREQ*DW  operand B, same packing
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accepts result
- rsp_sum  out  DW  low DW bits of a+b
- rsp_carry  out  1  bit DW of a+b
- rsp_id  out  $clog2(NREQ)  index of the requester that produced the result
- busy  out  1  high while state is HOLD
- op_count  out  CW  number of responses accepted downstream, wraps

Behaviour:
- Reset (rstn=0 at clk edge):
  - state=IDLE; rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, op_count=0.
  - last_grant=NREQ-1, so requester 0 has top priority first.
  - Reset mid-HOLD discards the held result with no handshake.
- FSM states:
  - IDLE: no result held.
  - HOLD: result registered, rsp_valid=1.
- can_accept = (state==IDLE) || (state==HOLD && rsp_ready). This is a combinational path rsp_ready -> req_ready, by design.
- Grant:
  - Round-robin over req_valid, starting at (last_grant+1) mod NREQ.
  - req_ready[g]=1 only when can_accept and req_valid[g]; all other bits 0.
- Accept (req_valid[g] && req_ready[g]):
  - Next edge: {rsp_carry,rsp_sum} <= req_a[g]+req_b[g] as a (DW+1)-bit unsigned add; rsp_id<=g; last_grant<=g; state->HOLD.
  - Latency: accept edge to rsp_valid high is 1 cycle.
- HOLD:
  - Hold rsp_* stable until rsp_valid && rsp_ready.
  - On that handshake with no new accept: state->IDLE, rsp_valid->0.
  - With a simultaneous accept: stay in HOLD and load the new result. This gives throughput of 1 op/cycle.
- last_grant changes only on accept. Requests not granted may drop valid freely; no grant is remembered.
- op_count increments by 1 on every response handshake and wraps from 2^CW-1 to 0.
- busy = (state==HOLD).
- Operand sampling: only the granted requester's operands are sampled, on the accept edge. Changes after the accept edge have no effect on the held result.
- No requests while IDLE: outputs hold their values (rsp_sum/rsp_carry/rsp_id keep last result), rsp_valid=0.

Decomposition:
- Package adder_share_pkg:
  - state_e enum {IDLE, HOLD}
  - default constants NREQ_DEF=4, DW_DEF=8, CW_DEF=16
  - function idx_w(n) returning $clog2(n) with minimum 1
- Sub-module rr_arbiter (param N):
  - in: req[N], last[$clog2(N)], en
  - out: gnt one-hot[N], gnt_idx
  - purely combinational; the pointer register stays in adder_share_arb.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with req_valid=4'b1111 -> req_ready=0 during reset; rsp_valid=0, op_count=0, busy=0. After release the first grant goes to requester 0.
- Single op with carry: req 2 sends a=8'hF0, b=8'h20, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=8'h10, rsp_carry=1, rsp_id=2, op_count becomes 1 after handshake.
- Round-robin fairness: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,... one per cycle; rsp_id follows the same sequence 1 cycle later; 8 results in 8 cycles.
- Backpressure: result held with rsp_ready=0 for 5 cycles while req 1 is valid -> rsp_* stable, req_ready=0. Raising rsp_ready accepts req 1 in the same cycle, with no bubble.
- Boundary add: a=8'hFF, b=8'h01 gives sum 8'h00, carry 1. a=8'h00, b=8'h00 gives sum 0, carry 0. a=8'h7F, b=8'h80 gives sum 8'hFF, carry 0.
- Reset mid-HOLD and counter wrap:
  - Assert rstn=0 while rsp_valid=1 -> rsp_valid=0 next edge; op_count=0.
  - Separately, preload via 65536 handshakes -> op_count wraps to 0.
